glb_dma: RTL

Word-streaming DMA engine that fills and drains the global buffer (GLB) on behalf of the host. It sits directly upstream of the accelerator top level, driving that level's DRAM-side GLB port (`dram_w_en`/`dram_w_addr`/`dram_w_data`, `dram_r_en`/`dram_r_addr`/`dram_r_data`). It loads ifmap, filter and bias regions before a pass and reads the opsum region back afterwards. One command moves `cmd_len` 32-bit words between a valid/ready stream and a word-aligned GLB byte address range.

---
 rtl/glb_dma.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/glb_dma.sv
// Word-streaming DMA between valid/ready streams and the GLB port.
// Loads write one word per accepted beat; stores read ahead into a 2-entry FIFO.
module glb_dma #(
  parameter int LEN_W  = 16,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_dir,
  input  logic [31:0]       cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic [3:0]        glb_we,
  output logic [31:0]       glb_w_addr,
  output logic [DATA_W-1:0] glb_w_data,
  output logic [3:0]        glb_re,
  output logic [31:0]       glb_r_addr,
  input  logic [DATA_W-1:0] glb_r_data
);
  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_STORE, S_DRAIN, S_FIN} state_t;
  state_t r_state, w_next;

  logic [31:0]       r_addr;
  logic [LEN_W-1:0]  r_rem;
  logic              r_err;
  logic [3:0]        r_glb_we;
  logic [31:0]       r_glb_w_addr;
  logic [DATA_W-1:0] r_glb_w_data;
  logic              r_rdv_p1;
  logic              r_rdv_last_p1;
  logic [DATA_W:0]   r_fifo [0:1];
  logic              r_wp, r_rp;
  logic [1:0]        r_cnt;

  logic       w_accept, w_beat, w_pop, w_issue, w_credit;
  logic [1:0] w_occ;

  assign cmd_ready = rst_n && (r_state == S_IDLE);
  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_FIN);
  assign err       = done && r_err;
  assign s_ready   = (r_state == S_LOAD) && (r_rem != '0);

  assign w_accept = cmd_valid && cmd_ready;
  assign w_beat   = s_valid && s_ready;
  assign m_valid  = (r_cnt != 2'd0);
  assign w_pop    = m_valid && m_ready;
  assign m_data   = r_fifo[r_rp][DATA_W-1:0];
  assign m_last   = m_valid && r_fifo[r_rp][DATA_W];

  // Occupancy counts FIFO words plus the read whose data arrives this cycle;
  // a simultaneous pop frees a slot so the stream can run at one word per cycle.
  assign w_occ    = r_cnt + {1'b0, r_rdv_p1};
  assign w_credit = (w_occ < 2'd2) || ((w_occ == 2'd2) && w_pop);
  assign w_issue  = rst_n && (r_state == S_STORE) && (r_rem != '0) && w_credit;

  assign glb_re     = w_issue ? 4'hF : 4'h0;
  assign glb_r_addr = r_addr;
  assign glb_we     = r_glb_we;
  assign glb_w_addr = r_glb_w_addr;
  assign glb_w_data = r_glb_w_data;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if ((cmd_addr[1:0] != 2'b00) || (cmd_len == '0)) w_next = S_FIN;
          else if (cmd_dir)                                w_next = S_STORE;
          else                                             w_next = S_LOAD;
        end
      end
      S_LOAD:  if (r_rem == '0) w_next = S_FIN;
      S_STORE: if ((r_rem == '0) || (w_issue && (r_rem == LEN_W'(1)))) w_next = S_DRAIN;
      S_DRAIN: if (!r_rdv_p1 && ((r_cnt == 2'd0) || ((r_cnt == 2'd1) && w_pop))) w_next = S_FIN;
      S_FIN:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state       <= S_IDLE;
      r_addr        <= '0;
      r_rem         <= '0;
      r_err         <= 1'b0;
      r_glb_we      <= 4'h0;
      r_glb_w_addr  <= '0;
      r_glb_w_data  <= '0;
      r_rdv_p1      <= 1'b0;
      r_rdv_last_p1 <= 1'b0;
      r_fifo[0]     <= '0;
      r_fifo[1]     <= '0;
      r_wp          <= 1'b0;
      r_rp          <= 1'b0;
      r_cnt         <= 2'd0;
    end else begin
      r_state  <= w_next;
      r_glb_we <= 4'h0;
      r_rdv_p1 <= w_issue;
      if (w_accept) begin
        r_addr <= cmd_addr;
        r_rem  <= cmd_len;
        r_err  <= (cmd_addr[1:0] != 2'b00);
      end
      if (w_beat) begin
        r_glb_we     <= 4'hF;
        r_glb_w_addr <= r_addr;
        r_glb_w_data <= s_data;
        r_addr       <= r_addr + 32'd4;
        r_rem        <= r_rem - LEN_W'(1);
      end
      if (w_issue) begin
        r_addr        <= r_addr + 32'd4;
        r_rem         <= r_rem - LEN_W'(1);
        r_rdv_last_p1 <= (r_rem == LEN_W'(1));
      end
      // Read data is valid one cycle after the read strobe
      if (r_rdv_p1) begin
        r_fifo[r_wp] <= {r_rdv_last_p1, glb_r_data};
        r_wp         <= ~r_wp;
      end
      if (w_pop) r_rp <= ~r_rp;
      r_cnt <= r_cnt + {1'b0, r_rdv_p1} - {1'b0, w_pop};
    end
  end

  a_fifo_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(r_rdv_p1 && (r_cnt == 2'd2)));

endmodule
